// File: rtl/encode_regfile_stream_pkg.sv
// regfile_pkg: shared layout constants for the trace register file frame.
// The word-order indices are also used by the trace-side unpacker, so both
// ends agree that word 0 is eax (frame bits 319:288) and word 9 is eflags.
package regfile_pkg;

   localparam int REGFILE_WORDS = 10;
   localparam int REG_W         = 32;
   localparam int REGFILE_W     = REGFILE_WORDS * REG_W;
   localparam int IDX_W         = 4;

   localparam logic [IDX_W-1:0] IDX_EAX    = 4'd0;
   localparam logic [IDX_W-1:0] IDX_EBX    = 4'd1;
   localparam logic [IDX_W-1:0] IDX_ECX    = 4'd2;
   localparam logic [IDX_W-1:0] IDX_EDX    = 4'd3;
   localparam logic [IDX_W-1:0] IDX_ESI    = 4'd4;
   localparam logic [IDX_W-1:0] IDX_EDI    = 4'd5;
   localparam logic [IDX_W-1:0] IDX_ESP    = 4'd6;
   localparam logic [IDX_W-1:0] IDX_EBP    = 4'd7;
   localparam logic [IDX_W-1:0] IDX_EIP    = 4'd8;
   localparam logic [IDX_W-1:0] IDX_EFLAGS = 4'd9;
   // Optional checksum word that trails eflags.
   localparam logic [IDX_W-1:0] IDX_CSUM   = 4'd10;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Packed frame: element 9 holds eax (MSBs), element 0 holds eflags.
   typedef logic [REGFILE_WORDS-1:0][REG_W-1:0] frame_t;

   // XOR of all register words of a frame.
   function automatic logic [REG_W-1:0] frame_xor(input frame_t f);
      logic [REG_W-1:0] acc;
      acc = {REG_W{1'b0}};
      for (int i = 0; i < REGFILE_WORDS; i++) begin
         acc = acc ^ f[i];
      end
      return acc;
   endfunction

endpackage

// File: rtl/encode_regfile_stream_if.sv
// encode_regfile_stream_if: input-side and output-side handshakes of the
// register-file stream encoder. The encoder uses the slave view, the
// surrounding logic (capture side + trace output path) the master view.
interface encode_regfile_stream_if;

   logic                           in_valid;
   logic                           in_ready;
   logic [regfile_pkg::REG_W-1:0]  out_data;
   logic                           out_valid;
   logic                           out_ready;
   logic                           out_last;

   modport master (
      output in_valid,
      input  in_ready,
      input  out_data,
      input  out_valid,
      input  out_last,
      output out_ready
   );

   modport slave (
      input  in_valid,
      output in_ready,
      output out_data,
      output out_valid,
      output out_last,
      input  out_ready
   );

endinterface

// File: rtl/encode_regfile_stream.sv
// encode_regfile_stream: snapshots ten 32-bit registers and streams them as
// 32-bit words, eax first, eflags last. Define ENCODE_REGFILE_CSUM_EN to
// append an 11th word holding the XOR of the ten register words.
// All outputs decode only from state, index and snapshot, so no input
// reaches an output combinationally.
module encode_regfile_stream
   import regfile_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [REG_W-1:0]       eax,
   input  logic [REG_W-1:0]       ebx,
   input  logic [REG_W-1:0]       ecx,
   input  logic [REG_W-1:0]       edx,
   input  logic [REG_W-1:0]       esi,
   input  logic [REG_W-1:0]       edi,
   input  logic [REG_W-1:0]       esp,
   input  logic [REG_W-1:0]       ebp,
   input  logic [REG_W-1:0]       eip,
   input  logic [REG_W-1:0]       eflags,
   encode_regfile_stream_if.slave bus,
   output logic                   busy
);

`ifdef ENCODE_REGFILE_CSUM_EN
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_CSUM;
`else
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_EFLAGS;
`endif

   state_t           state_r;
   state_t           next_state_s;
   logic [IDX_W-1:0] idx_r;
   logic [IDX_W-1:0] next_idx_s;
   frame_t           snap_r;
   logic             load_s;
   logic [IDX_W-1:0] sel_s;
   logic [REG_W-1:0] word_s;

   // State, word index and snapshot; reset drops any frame in flight at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         idx_r   <= {IDX_W{1'b0}};
         snap_r  <= {REGFILE_W{1'b0}};
      end else begin
         state_r <= next_state_s;
         idx_r   <= next_idx_s;
         if (load_s) begin
            snap_r <= {eax, ebx, ecx, edx, esi, edi, esp, ebp, eip, eflags};
         end
      end
   end

   // Next-state logic: capture in IDLE, advance one word per accepted handshake
   always_comb begin
      next_state_s = state_r;
      next_idx_s   = idx_r;
      load_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.in_valid) begin
               load_s       = 1'b1;
               next_idx_s   = IDX_EAX;
               next_state_s = SEND;
            end else begin
               next_state_s = IDLE;
            end
         end
         SEND: begin
            if (bus.out_ready) begin
               if (idx_r == LAST_IDX) begin
                  next_state_s = IDLE;
                  next_idx_s   = IDX_EAX;
               end else begin
                  next_idx_s = idx_r + 4'd1;
               end
            end else begin
               next_idx_s = idx_r;
            end
         end
         default: begin
            next_state_s = IDLE;
            next_idx_s   = IDX_EAX;
         end
      endcase
   end

   // Word k of the stream sits at packed element (9 - k) of the snapshot
   assign sel_s = IDX_EFLAGS - idx_r;

   // Select the word presented at the current index
   always_comb begin
      word_s = {REG_W{1'b0}};
`ifdef ENCODE_REGFILE_CSUM_EN
      if (idx_r == IDX_CSUM) begin
         word_s = frame_xor(snap_r);
      end else begin
         word_s = snap_r[sel_s];
      end
`else
      word_s = snap_r[sel_s];
`endif
   end

   // Output decode from state and index only
   always_comb begin
      bus.in_ready  = (state_r == IDLE);
      bus.out_valid = (state_r == SEND);
      bus.out_last  = (state_r == SEND) && (idx_r == LAST_IDX);
      busy          = (state_r == SEND);
      if (state_r == SEND) begin
         bus.out_data = word_s;
      end else begin
         bus.out_data = {REG_W{1'b0}};
      end
   end

endmodule

// File: tb/tb_encode_regfile_stream.sv
// tb_encode_regfile_stream: randomized self-checking bench for the register
// file stream encoder. The reference is a per-frame list of expected words
// and an MSB-first unpacker of the received stream.
`timescale 1ns/1ps
module tb_encode_regfile_stream;
   import regfile_pkg::*;

`ifdef ENCODE_REGFILE_CSUM_EN
   localparam int NW = 11;
`else
   localparam int NW = 10;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] regs_in [10];
   logic        busy;
   int          check_cnt = 0;
   int          err_cnt = 0;
   logic [31:0] exp_words [NW];

   encode_regfile_stream_if bus();

   encode_regfile_stream dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .eax    (regs_in[0]),
      .ebx    (regs_in[1]),
      .ecx    (regs_in[2]),
      .edx    (regs_in[3]),
      .esi    (regs_in[4]),
      .edi    (regs_in[5]),
      .esp    (regs_in[6]),
      .ebp    (regs_in[7]),
      .eip    (regs_in[8]),
      .eflags (regs_in[9]),
      .bus    (bus),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected stream: the ten registers in order, plus their XOR if enabled.
   task automatic build_exp();
      logic [31:0] x;
      x = 32'h0;
      for (int k = 0; k < 10; k++) begin
         exp_words[k] = regs_in[k];
         x = x ^ regs_in[k];
      end
`ifdef ENCODE_REGFILE_CSUM_EN
      exp_words[10] = x;
`endif
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      for (int k = 0; k < 10; k++) regs_in[k] = 32'h0;
      rst_n = 1'b0;
      #12;
      check_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      check_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      check_cnt++; if (bus.out_last !== 1'b0) begin err_cnt++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
      check_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
      check_cnt++; if (bus.out_data !== 32'h0) begin err_cnt++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
      #6 rst_n = 1'b1;
      step();
      check_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL post_reset_out_valid got %b want 0", bus.out_valid); end
   endtask

   task automatic test_single_frame();
      for (int k = 0; k < 10; k++) regs_in[k] = 32'(k + 1);
      build_exp();
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      check_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL single_in_ready got %b want 1", bus.in_ready); end
      step();
      bus.in_valid = 1'b0;
      for (int w = 0; w < NW; w++) begin
         check_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_words[w])
            begin err_cnt++; $display("FAIL single_word%0d got v=%b %h want v=1 %h", w, bus.out_valid, bus.out_data, exp_words[w]); end
         check_cnt++; if (bus.out_last !== (w == NW - 1))
            begin err_cnt++; $display("FAIL single_last%0d got %b want %b", w, bus.out_last, (w == NW - 1)); end
         check_cnt++; if (busy !== 1'b1 || bus.in_ready !== 1'b0)
            begin err_cnt++; $display("FAIL single_busy%0d got busy=%b rdy=%b want 1/0", w, busy, bus.in_ready); end
         step();
      end
      check_cnt++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
         begin err_cnt++; $display("FAIL single_end got rdy=%b v=%b want 1/0", bus.in_ready, bus.out_valid); end
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < 10; k++) regs_in[k] = 32'(k + 1);
      build_exp();
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      for (int w = 0; w < NW; w++) begin
         if (w == 3) begin
            bus.out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               check_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h4 || bus.out_last !== 1'b0)
                  begin err_cnt++; $display("FAIL bp_hold%0d got v=%b %h l=%b want v=1 00000004 l=0", s, bus.out_valid, bus.out_data, bus.out_last); end
               step();
            end
            bus.out_ready = 1'b1;
         end
         check_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_words[w] || bus.out_last !== (w == NW - 1))
            begin err_cnt++; $display("FAIL bp_word%0d got v=%b %h l=%b want %h", w, bus.out_valid, bus.out_data, bus.out_last, exp_words[w]); end
         step();
      end
      check_cnt++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
         begin err_cnt++; $display("FAIL bp_end got rdy=%b v=%b want 1/0", bus.in_ready, bus.out_valid); end
   endtask

   task automatic test_input_change();
      for (int k = 0; k < 10; k++) regs_in[k] = $urandom;
      regs_in[0] = 32'hDEADBEEF;
      build_exp();
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      step();
      regs_in[0] = 32'h12345678;
      for (int k = 1; k < 10; k++) regs_in[k] = $urandom;
      for (int w = 0; w < NW; w++) begin
         check_cnt++; if (bus.out_data !== exp_words[w] || bus.in_ready !== 1'b0)
            begin err_cnt++; $display("FAIL chg_word%0d got %h rdy=%b want %h rdy=0", w, bus.out_data, bus.in_ready, exp_words[w]); end
         step();
      end
      check_cnt++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
         begin err_cnt++; $display("FAIL chg_end got rdy=%b v=%b want 1/0", bus.in_ready, bus.out_valid); end
      bus.in_valid = 1'b0;
      step();
      check_cnt++; if (bus.out_valid !== 1'b0)
         begin err_cnt++; $display("FAIL chg_idle got v=%b want 0", bus.out_valid); end
   endtask

   task automatic test_reset_mid_frame();
      for (int k = 0; k < 10; k++) regs_in[k] = 32'(k + 1);
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      for (int w = 0; w < 5; w++) step();
      check_cnt++; if (bus.out_data !== 32'h6)
         begin err_cnt++; $display("FAIL rst_pre got %h want 00000006", bus.out_data); end
      #1 rst_n = 1'b0;
      #1;
      check_cnt++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1)
         begin err_cnt++; $display("FAIL rst_async got v=%b busy=%b rdy=%b want 0/0/1", bus.out_valid, busy, bus.in_ready); end
      step();
      rst_n = 1'b1;
      step();
      check_cnt++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.in_ready !== 1'b1)
         begin err_cnt++; $display("FAIL rst_release got v=%b %h rdy=%b want 0 0 1", bus.out_valid, bus.out_data, bus.in_ready); end
      for (int k = 0; k < 10; k++) regs_in[k] = $urandom;
      build_exp();
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      for (int w = 0; w < NW; w++) begin
         check_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_words[w] || bus.out_last !== (w == NW - 1))
            begin err_cnt++; $display("FAIL rst_new%0d got v=%b %h l=%b want %h", w, bus.out_valid, bus.out_data, bus.out_last, exp_words[w]); end
         step();
      end
      check_cnt++; if (bus.out_valid !== 1'b0)
         begin err_cnt++; $display("FAIL rst_new_end got v=%b want 0", bus.out_valid); end
   endtask

   task automatic test_round_trip();
      logic [31:0]  sent [10];
      logic [31:0]  got [$];
      logic [319:0] raw;
      logic [31:0]  hold;
      logic         stall;
      logic         rdy;
      int           cyc;
      for (int f = 0; f < 1000; f++) begin
         for (int k = 0; k < 10; k++) begin
            regs_in[k] = $urandom;
            sent[k] = regs_in[k];
         end
         build_exp();
         bus.in_valid = 1'b1;
         check_cnt++; if (bus.in_ready !== 1'b1)
            begin err_cnt++; $display("FAIL rt_in_ready frame %0d got %b want 1", f, bus.in_ready); end
         step();
         bus.in_valid = 1'b0;
         for (int k = 0; k < 10; k++) regs_in[k] = $urandom;
         got.delete();
         cyc = 0;
         stall = 1'b0;
         hold = 32'h0;
         while (got.size() < NW && cyc < 400) begin
            if (stall) begin
               check_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== hold)
                  begin err_cnt++; $display("FAIL rt_stall frame %0d got v=%b %h want v=1 %h", f, bus.out_valid, bus.out_data, hold); end
            end
            rdy = ($urandom_range(0, 3) != 0);
            bus.out_ready = rdy;
            if (bus.out_valid === 1'b1 && rdy) begin
               check_cnt++; if (bus.out_last !== (got.size() == NW - 1))
                  begin err_cnt++; $display("FAIL rt_last frame %0d word %0d got %b", f, got.size(), bus.out_last); end
               got.push_back(bus.out_data);
               stall = 1'b0;
            end else begin
               stall = (bus.out_valid === 1'b1);
               hold = bus.out_data;
            end
            step();
            cyc++;
         end
         bus.out_ready = 1'b0;
         check_cnt++;
         if (got.size() != NW) begin
            err_cnt++;
            $display("FAIL rt_timeout frame %0d got %0d words want %0d", f, got.size(), NW);
         end else begin
            raw = 320'h0;
            for (int i = 0; i < 10; i++) raw = {raw[287:0], got[i]};
            for (int k = 0; k < 10; k++) begin
               check_cnt++; if (raw[319 - 32 * k -: 32] !== sent[k])
                  begin err_cnt++; $display("FAIL rt_reg%0d frame %0d got %h want %h", k, f, raw[319 - 32 * k -: 32], sent[k]); end
            end
`ifdef ENCODE_REGFILE_CSUM_EN
            check_cnt++; if (got[10] !== exp_words[10])
               begin err_cnt++; $display("FAIL rt_csum frame %0d got %h want %h", f, got[10], exp_words[10]); end
`endif
         end
      end
      step();
      check_cnt++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
         begin err_cnt++; $display("FAIL rt_end got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_backpressure();
      test_input_change();
      test_reset_mid_frame();
      test_round_trip();
      $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
      $finish;
   end

endmodule
